// File: rtl/contador_pkg.sv
// contador_pkg: mode codes, FSM state type and captured-command bundle
// shared by the counter controller and its timer.
package contador_pkg;

  localparam logic [1:0] MODE_UP1  = 2'b00;
  localparam logic [1:0] MODE_DN1  = 2'b01;
  localparam logic [1:0] MODE_DN3  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LWAIT,
    RUN,
    DRAIN,
    RESP
  } state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] data;
    logic       inf;
  } cmd_t;

  function automatic logic is_load(
    input logic [1:0] op
  );
    return op == MODE_LOAD;
  endfunction

endpackage

// File: rtl/contador_ctrl_timer.sv
// contador_ctrl_timer: loadable down counter with zero flag; holds at 0.
// Shared between run-length counting and the load/run timeouts.
module contador_ctrl_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/contador_ctrl.sv
// contador_ctrl: sequences one host command at a time onto a 4-bit
// counter and reports the settled Q, rco and timeout status.
module contador_ctrl
  import contador_pkg::*;
#(
  parameter int LEN_W        = 8,
  parameter int LOAD_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_value,
  output logic             rsp_rco,
  output logic             rsp_err,
  output logic             enable,
  output logic [1:0]       mode,
  output logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             load,
  input  logic             rco
);

  state_e state_q;
  state_e state_d;

  cmd_t       cmd_q;
  cmd_t       cmd_d;
  logic       rco_q;
  logic       rco_d;
  logic       err_q;
  logic       err_d;
  logic [3:0] val_q;
  logic [3:0] val_d;

  logic             accept;
  logic             t_load;
  logic             t_dec;
  logic [LEN_W-1:0] t_val;
  logic [LEN_W-1:0] t_cnt;
  logic             t_zero;
  logic             last;
  logic             lwait_to;
  logic             run_to;

  assign accept = cmd_valid && (state_q == IDLE);
  assign last   = (t_cnt == LEN_W'(1)) || t_zero;

  assign lwait_to = (state_q == LWAIT) && !load && last;
  assign run_to   = (state_q == RUN) && cmd_q.inf
                  && !rco && last;

  // len=0 runs are bounded by an all-ones count as a watchdog
  always_comb begin
    t_load = accept || (state_q == LOAD);
    t_dec  = (state_q == RUN) || (state_q == LWAIT);
    t_val  = LEN_W'(LOAD_TIMEOUT);
    if (accept) begin
      t_val = (cmd_len == '0) ? '1 : cmd_len;
    end
  end

  contador_ctrl_timer #(
    .W (LEN_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (t_load),
    .val_i  (t_val),
    .dec_i  (t_dec),
    .cnt_o  (t_cnt),
    .zero_o (t_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = is_load(cmd_op) ? LOAD : RUN;
        end
      end
      LOAD: begin
        state_d = LWAIT;
      end
      LWAIT: begin
        if (load) begin
          state_d = DRAIN;
        end else if (last) begin
          state_d = RESP;
        end
      end
      RUN: begin
        if (cmd_q.inf) begin
          if (rco || last) begin
            state_d = DRAIN;
          end
        end else if (last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_d = cmd_q;
    rco_d = rco_q;
    err_d = err_q;
    val_d = val_q;
    if (accept) begin
      cmd_d.op   = cmd_op;
      cmd_d.data = cmd_data;
      cmd_d.inf  = (cmd_len == '0);
      rco_d      = 1'b0;
      err_d      = 1'b0;
    end
    if (((state_q == RUN) || (state_q == DRAIN)) && rco) begin
      rco_d = 1'b1;
    end
    if (lwait_to || run_to) begin
      err_d = 1'b1;
    end
    if ((state_d == RESP) && (state_q != RESP)) begin
      val_d = Q;
    end
    if ((state_q == RESP) && rsp_ready) begin
      rco_d = 1'b0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q <= '0;
      rco_q <= 1'b0;
      err_q <= 1'b0;
      val_q <= '0;
    end else begin
      cmd_q <= cmd_d;
      rco_q <= rco_d;
      err_q <= err_d;
      val_q <= val_d;
    end
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    enable    = 1'b0;
    mode      = MODE_UP1;
    D         = '0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
      end
      LOAD: begin
        mode = MODE_LOAD;
        D    = cmd_q.data;
      end
      RUN: begin
        enable = 1'b1;
        mode   = cmd_q.op;
      end
      RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  assign rsp_value = val_q;
  assign rsp_rco   = rco_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// tb_contador_ctrl: directed checks of contador_ctrl against a small
// behavioural 4-bit counter with registered Q/load/rco.
module tb_contador_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_len;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_value;
  logic       rsp_rco;
  logic       rsp_err;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] D;
  logic [3:0] Q;
  logic       load;
  logic       rco;

  logic [3:0] cq;
  logic       cld;
  logic       crc;
  logic       tie_load;
  logic       tie_rco;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int ens;
  int nload;
  logic [3:0] dseen;
  logic seen;

  always #5 clk = ~clk;

  contador_ctrl #(
    .LEN_W        (8),
    .LOAD_TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_value (rsp_value),
    .rsp_rco   (rsp_rco),
    .rsp_err   (rsp_err),
    .enable    (enable),
    .mode      (mode),
    .D         (D),
    .Q         (Q),
    .load      (load),
    .rco       (rco)
  );

  // counter: mode 11 loads D regardless of enable; rco flags a wrap
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cq  <= '0;
      cld <= 1'b0;
      crc <= 1'b0;
    end else begin
      cld <= 1'b0;
      crc <= 1'b0;
      if (mode == 2'b11) begin
        cq  <= D;
        cld <= 1'b1;
      end else if (enable) begin
        case (mode)
          2'b00: {crc, cq} <= {1'b0, cq} + 5'd1;
          2'b01: begin
            crc <= (cq < 4'd1);
            cq  <= cq - 4'd1;
          end
          default: begin
            crc <= (cq < 4'd3);
            cq  <= cq - 4'd3;
          end
        endcase
      end
    end
  end

  assign Q    = cq;
  assign load = cld & ~tie_load;
  assign rco  = crc & ~tie_rco;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op,
                        input logic [3:0] dat,
                        input logic [7:0] len,
                        input int lim);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = dat;
    cmd_len   = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat   = 1;
    ens   = 0;
    nload = 0;
    dseen = '0;
    while (!rsp_valid && lat < lim) begin
      ens += int'(enable);
      if (mode == 2'b11) begin
        nload++;
        dseen = D;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_valid_seen", 32'(rsp_valid), 1);
  endtask

  task automatic hs();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_idle", 32'({rsp_valid, cmd_ready}), 2'b01);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_len   = '0;
    rsp_ready = 1'b0;
    tie_load  = 1'b0;
    tie_rco   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'({cmd_ready, rsp_valid, rsp_value,
        rsp_rco, rsp_err, enable, mode, D}), 15'h4000);
    reset = 1'b0;
    @(posedge clk); #1;

    do_cmd(2'b11, 4'ha, 8'd0, 20);
    chk("ld_lat", lat, 4);
    chk("ld_cycles", nload, 1);
    chk("ld_D", 32'(dseen), 4'ha);
    chk("ld_ens", ens, 0);
    chk("ld_rsp", 32'({rsp_value, rsp_rco, rsp_err}), {4'ha, 2'b00});
    chk("ld_busy", 32'(cmd_ready), 0);
    hs();

    do_cmd(2'b11, 4'h0, 8'd0, 20);
    hs();
    do_cmd(2'b00, 4'h0, 8'd5, 20);
    chk("up5_lat", lat, 7);
    chk("up5_ens", ens, 5);
    chk("up5_rsp", 32'({rsp_value, rsp_rco, rsp_err}), {4'h5, 2'b00});
    hs();

    do_cmd(2'b11, 4'he, 8'd0, 20);
    chk("lde_val", 32'(rsp_value), 4'he);
    hs();
    do_cmd(2'b00, 4'h0, 8'd0, 20);
    chk("wrap_lat", lat, 5);
    chk("wrap_ens", ens, 3);
    chk("wrap_rsp", 32'({rsp_value, rsp_rco, rsp_err}), {4'h1, 2'b10});
    hs();

    do_cmd(2'b11, 4'h4, 8'd0, 20);
    hs();
    do_cmd(2'b10, 4'h0, 8'd2, 20);
    chk("dn3_lat", lat, 4);
    chk("dn3_ens", ens, 2);
    chk("dn3_rsp", 32'({rsp_value, rsp_rco, rsp_err}), {4'he, 2'b10});
    hs();

    tie_load = 1'b1;
    do_cmd(2'b11, 4'h5, 8'd0, 20);
    chk("lto_lat", lat, 6);
    chk("lto_flags", 32'({rsp_rco, rsp_err}), 2'b01);
    hs();
    tie_load = 1'b0;
    chk("lto_clear", 32'({rsp_rco, rsp_err}), 2'b00);

    do_cmd(2'b01, 4'h0, 8'd3, 20);
    chk("bp_lat", lat, 5);
    chk("bp_ens", ens, 3);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_data  = 4'hf;
    cmd_len   = '0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 32'({rsp_valid, cmd_ready, rsp_value,
          rsp_rco, rsp_err, Q}), {2'b10, 4'h2, 2'b00, 4'h2});
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    hs();
    do_cmd(2'b11, 4'hf, 8'd0, 20);
    chk("bp_next", 32'({lat[3:0], rsp_value}), {4'd4, 4'hf});
    hs();

    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_len   = 8'd20;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("mid_running", 32'(enable), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async", 32'({cmd_ready, rsp_valid, enable, mode,
        D, rsp_rco, rsp_err}), 11'h400);
    @(posedge clk); #1;
    reset = 1'b0;
    seen  = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("rst_no_rsp", 32'({seen, cmd_ready}), 2'b01);
    do_cmd(2'b11, 4'h3, 8'd0, 20);
    chk("rst_ld", 32'({lat[3:0], rsp_value}), {4'd4, 4'h3});
    hs();
    do_cmd(2'b00, 4'h0, 8'd1, 20);
    chk("len1", 32'({lat[3:0], ens[3:0], rsp_value}),
        {4'd3, 4'd1, 4'h4});
    hs();

    tie_rco = 1'b1;
    do_cmd(2'b00, 4'h0, 8'd0, 300);
    chk("rto_lat", lat, 257);
    chk("rto_ens", ens, 255);
    chk("rto_rsp", 32'({rsp_value, rsp_rco, rsp_err}), {4'h3, 2'b01});
    hs();
    tie_rco = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/contador_ctrl.md
CONTADOR_CTRL -- requirements
Module: contador_ctrl

Interface
REQ-001 Parameter LEN_W, default 8, width of the cycle-count field and the internal run counter.
REQ-002 Parameter LOAD_TIMEOUT, default 4, maximum cycles to wait for counter load acknowledge.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_ready  output  1  controller idle, accepts a command.
REQ-007 cmd_op  input  2  counter mode to apply: 00 up-by-1, 01 down-by-1, 10 down-by-3, 11 load.
REQ-008 cmd_data  input  4  load value, used only when cmd_op=11.
REQ-009 cmd_len  input  LEN_W  enabled cycles to run; 0 means run until rco.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  host accepts response.
REQ-012 rsp_value  output  4  counter Q sampled at completion.
REQ-013 rsp_rco  output  1  rco observed at least once during the command.
REQ-014 rsp_err  output  1  timeout: load not acknowledged, or len=0 run hit 2^LEN_W-1 cycles without rco.
REQ-015 enable, mode[1:0], D[3:0]  outputs  drive the 4-bit counter's enable, mode, D.
REQ-016 Q[3:0], load, rco  inputs  from the 4-bit counter (registered outputs).

Function
REQ-017 FSM states SHALL be IDLE, LOAD, LWAIT, RUN, DRAIN, RESP.
REQ-018 IDLE: cmd_ready=1, enable=0, mode=00, D=0; cmd_valid&cmd_ready captures op/data/len; op=11 -> LOAD, else -> RUN.
REQ-019 cmd_ready SHALL be 0 in every state except IDLE; commands offered while busy are not consumed.
REQ-020 LOAD (one cycle): mode=11, D=captured data, enable=0; -> LWAIT.
REQ-021 LWAIT: mode=00, enable=0; load=1 -> DRAIN; after LOAD_TIMEOUT cycles without load -> RESP with rsp_err=1.
REQ-022 RUN: enable=1, mode=captured op; run counter loaded with cmd_len on accept, decremented each RUN cycle; count reaching 0 after the current cycle -> DRAIN.
REQ-023 RUN with cmd_len=0: stays until rco=1 sampled -> DRAIN; at 2^LEN_W-1 cycles without rco -> DRAIN with rsp_err=1.
REQ-024 rco=1 sampled in any RUN or DRAIN cycle SHALL set sticky rsp_rco for the current command.
REQ-025 DRAIN (one cycle): enable=0, mode=00; lets the counter's registered Q settle; -> RESP, latching rsp_value=Q at the DRAIN->RESP edge.
REQ-026 RESP: rsp_valid=1, rsp_value/rsp_rco/rsp_err stable until rsp_valid&rsp_ready; then -> IDLE, flags cleared.
REQ-027 Latency: cmd_len=N>0 gives exactly N cycles of enable=1; rsp_valid rises N+2 cycles after the accept edge.
REQ-028 Load latency: rsp_valid rises 4 cycles after accept when load returns on the first LWAIT cycle.
REQ-029 Run counter SHALL be unsigned LEN_W bits and never wrap below 0.

Reset
REQ-030 reset SHALL force IDLE asynchronously: cmd_ready=1, rsp_valid=0, rsp_value=0, rsp_rco=0, rsp_err=0, enable=0, mode=00, D=0, run counter=0.
REQ-031 Reset mid-command SHALL abort it with no response; the first post-reset accept starts a fresh command.

Structure
REQ-032 Shared package contador_pkg SHALL hold mode constants (MODE_UP1, MODE_DN1, MODE_DN3, MODE_LOAD) and the FSM state type.
REQ-033 One sub-module contador_ctrl_timer SHALL implement the loadable LEN_W-bit down counter with zero flag, reused for run length and timeouts.

Verification
REQ-034 Load: op=11, data=1010 -> one LOAD cycle with mode=11, D=1010; rsp_value=1010, rsp_rco=0, rsp_err=0.
REQ-035 Up count: load 0000, then op=00, len=5 -> exactly 5 enable cycles; rsp_value=0101.
REQ-036 Wrap: load 1110, op=00, len=0 -> runs until rco; rsp_rco=1, rsp_err=0.
REQ-037 Load timeout: tie load=0, op=11 -> rsp_err=1 after LOAD_TIMEOUT LWAIT cycles.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and fields stable; cmd_ready=0; second command accepted only after the response handshake.
REQ-039 Reset mid-RUN (op=01, len=20, reset at cycle 7) -> immediate idle outputs, no rsp_valid, next command executes normally.
